countdown_ctrl: RTL and testbench
=================================

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter ALARM_TICKS, default 5, SHALL set the number of TICK strobes ALARM stays high (legal range 1..15).
REQ-002 Parameter AUTO_RELOAD, default 0, SHALL select the exit from ALARM: 0 = IDLE holding 00; 1 = reload stored preset and RUN.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 MR  input  1  reset, asynchronous, active-high.
REQ-005 LD  input  1  level, sampled per clock; loads PRE_T/PRE_U.
REQ-006 PRE_T  input  4  preset tens digit, BCD.
REQ-007 PRE_U  input  4  preset units digit, BCD.
REQ-008 START  input  1  level, sampled per clock; start or resume.
REQ-009 PAUSE  input  1  level, sampled per clock; suspend counting.
REQ-010 TICK  input  1  one-clock count strobe from the prescaler.
REQ-011 Q_T  output  4  current tens digit, registered.
REQ-012 Q_U  output  4  current units digit, registered.
REQ-013 BUSY  output  1  high in RUN or PAUSED.
REQ-014 DONE  output  1  one-clock pulse on reaching 00.
REQ-015 ALARM  output  1  high in ALARM state.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RUN, PAUSED, ALARM.
REQ-017 Command priority per clock SHALL be MR > LD > START > PAUSE > TICK.
REQ-018 LD in any state SHALL, at the next edge, load Q_T/Q_U and the stored preset from PRE_T/PRE_U, clear the alarm tick counter, and enter IDLE.
REQ-019 A preset digit >9 SHALL be clamped to 9 on load.
REQ-020 START in IDLE SHALL enter RUN only if {Q_T,Q_U} != 00; otherwise ignored.
REQ-021 START in PAUSED SHALL enter RUN; START in RUN or ALARM SHALL be ignored.
REQ-022 PAUSE in RUN SHALL enter PAUSED; a TICK in that same cycle SHALL be discarded.
REQ-023 In RUN on TICK: Q_U != 0 -> Q_U-1; Q_U == 0 -> Q_U=9 and Q_T-1 (decade borrow).
REQ-024 Digits SHALL never leave 0..9; no count change outside RUN except by LD or reload.
REQ-025 TICK when count is 01 in RUN SHALL make count 00 and enter ALARM at the same edge.
REQ-026 DONE SHALL be high for exactly the one clock following that edge, registered, never otherwise.
REQ-027 In ALARM, each TICK SHALL increment the alarm counter; on the ALARM_TICKS-th TICK the FSM SHALL exit per AUTO_RELOAD at that edge.
REQ-028 AUTO_RELOAD=1 exit SHALL load the stored preset; if stored preset is 00, exit SHALL be to IDLE.
REQ-029 PAUSE and START in ALARM SHALL be ignored; only LD or MR abort ALARM.
REQ-030 BUSY and ALARM SHALL be decoded from the registered state, glitch-free.
REQ-031 TICK in IDLE or PAUSED SHALL have no effect.

Reset
REQ-032 MR high SHALL immediately force state IDLE, Q_T=0, Q_U=0, stored preset 00, alarm counter 0, BUSY=0, DONE=0, ALARM=0.
REQ-033 MR asserted mid-RUN or mid-ALARM SHALL abort without a DONE pulse; after release, START is ignored until LD loads a nonzero value.
REQ-034 Release of MR SHALL take effect with no extra cycles; first edge after release obeys REQ-017.

Verification
REQ-035 LD 2/3, START, 23 TICKs -> count 23,22..20,19..01,00; DONE one clock after 00 edge; ALARM high; after 5 more TICKs -> IDLE, ALARM=0, count 00.
REQ-036 LD 1/0, START, 3 TICKs, PAUSE with TICK same cycle, 4 TICKs, START, 1 TICK -> 10,09,08,07 hold at 07 while PAUSED (BUSY=1), then 06.
REQ-037 LD PRE_T=12, PRE_U=15 -> Q_T=9, Q_U=9; START with count 00 after reset -> stays IDLE, BUSY=0.
REQ-038 AUTO_RELOAD=1, LD 0/2, START, 2 TICKs, 5 ALARM TICKs -> reloads 02, RUN, BUSY=1, second DONE after 2 more TICKs.
REQ-039 MR pulsed asynchronously mid-RUN at count 45 -> outputs zero before next CLK edge, no DONE; LD+START same cycle -> LD wins, state IDLE.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown controller.
// A preset (00..99) is loaded, counted down one step per TICK strobe while
// running, and on reaching 00 the block raises ALARM for ALARM_TICKS strobes.
// On leaving ALARM it either idles at 00 or reloads the stored preset and
// runs again. DONE is a one-clock pulse marking the clock after the 01->00 step.
module countdown_ctrl #(
  parameter int unsigned ALARM_TICKS = 5,    // ALARM duration in TICK strobes, 1..15
  parameter bit          AUTO_RELOAD = 1'b0  // 1: reload the stored preset after ALARM
) (
  input  logic       CLK,
  input  logic       MR,
  input  logic       LD,
  input  logic [3:0] PRE_T,
  input  logic [3:0] PRE_U,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       TICK,
  output logic [3:0] Q_T,
  output logic [3:0] Q_U,
  output logic       BUSY,
  output logic       DONE,
  output logic       ALARM
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_ALARM  = 2'd3
  } state_t;

  // Value of the alarm counter on the strobe that ends ALARM.
  localparam logic [3:0] LAST_ALARM = 4'(ALARM_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_t_q, cnt_t_d;
  logic [3:0] cnt_u_q, cnt_u_d;
  logic [3:0] pre_t_q, pre_t_d;
  logic [3:0] pre_u_q, pre_u_d;
  logic [3:0] acnt_q,  acnt_d;
  logic       done_q,  done_d;
  logic       busy_q,  busy_d;
  logic       alarm_q, alarm_d;

  logic cnt_is_zero;
  logic cnt_is_one;
  logic pre_is_zero;

  // Out-of-range BCD preset digits saturate at 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign cnt_is_zero = (cnt_t_q == 4'd0) && (cnt_u_q == 4'd0);
  assign cnt_is_one  = (cnt_t_q == 4'd0) && (cnt_u_q == 4'd1);
  assign pre_is_zero = (pre_t_q == 4'd0) && (pre_u_q == 4'd0);

  // Next-state decode: commands resolved in priority order LD > START > PAUSE > TICK.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    cnt_t_d = cnt_t_q;
    cnt_u_d = cnt_u_q;
    pre_t_d = pre_t_q;
    pre_u_d = pre_u_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;

    if (LD) begin
      cnt_t_d = clamp_bcd(PRE_T);
      cnt_u_d = clamp_bcd(PRE_U);
      pre_t_d = clamp_bcd(PRE_T);
      pre_u_d = clamp_bcd(PRE_U);
      acnt_d  = 4'd0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A zero count has nothing to run down, so START is ignored.
          if (START && !cnt_is_zero) state_d = S_RUN;
        end

        S_RUN: begin
          // START is meaningless while running; PAUSE swallows a same-cycle TICK.
          if (PAUSE) begin
            state_d = S_PAUSED;
          end else if (TICK) begin
            if (cnt_is_one) begin
              cnt_u_d = 4'd0;
              acnt_d  = 4'd0;
              done_d  = 1'b1;
              state_d = S_ALARM;
            end else if (cnt_u_q != 4'd0) begin
              cnt_u_d = cnt_u_q - 4'd1;
            end else begin
              cnt_u_d = 4'd9;
              cnt_t_d = cnt_t_q - 4'd1;
            end
          end
        end

        S_PAUSED: begin
          if (START) state_d = S_RUN;
        end

        S_ALARM: begin
          // Only LD or MR abort ALARM; START and PAUSE are ignored here.
          if (TICK) begin
            if (acnt_q == LAST_ALARM) begin
              acnt_d = 4'd0;
              if (AUTO_RELOAD && !pre_is_zero) begin
                cnt_t_d = pre_t_q;
                cnt_u_d = pre_u_q;
                state_d = S_RUN;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              acnt_d = acnt_q + 4'd1;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Status flags are derived from the next state and then registered,
    // so BUSY and ALARM come straight from flops.
    busy_d  = (state_d == S_RUN) || (state_d == S_PAUSED);
    alarm_d = (state_d == S_ALARM);
  end

  // State and output registers; MR clears everything immediately.
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state_q <= S_IDLE;
      cnt_t_q <= 4'd0;
      cnt_u_q <= 4'd0;
      pre_t_q <= 4'd0;
      pre_u_q <= 4'd0;
      acnt_q  <= 4'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values and the update order inside the block is irrelevant.
      state_q <= state_d;
      cnt_t_q <= cnt_t_d;
      cnt_u_q <= cnt_u_d;
      pre_t_q <= pre_t_d;
      pre_u_q <= pre_u_d;
      acnt_q  <= acnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      alarm_q <= alarm_d;
    end
  end

  assign Q_T   = cnt_t_q;
  assign Q_U   = cnt_u_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ALARM = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Testbench for countdown_ctrl. Two instances share all inputs: one idles
// after ALARM, the other auto-reloads. A behavioural model counts in plain
// integers (0..99) and drives the randomized comparison.
module tb_countdown_ctrl;

  localparam int ALARM_N = 5;

  logic       CLK = 1'b0;
  logic       MR, LD, START, PAUSE, TICK;
  logic [3:0] PRE_T, PRE_U;

  logic [3:0] qt_a, qu_a, qt_b, qu_b;
  logic       busy_a, done_a, alarm_a, busy_b, done_b, alarm_b;
  logic [10:0] obs_a, obs_b;

  int checks = 0;
  int errors = 0;

  countdown_ctrl #(.ALARM_TICKS(ALARM_N), .AUTO_RELOAD(1'b0)) dut_a (
    .CLK(CLK), .MR(MR), .LD(LD), .PRE_T(PRE_T), .PRE_U(PRE_U),
    .START(START), .PAUSE(PAUSE), .TICK(TICK),
    .Q_T(qt_a), .Q_U(qu_a), .BUSY(busy_a), .DONE(done_a), .ALARM(alarm_a)
  );

  countdown_ctrl #(.ALARM_TICKS(ALARM_N), .AUTO_RELOAD(1'b1)) dut_b (
    .CLK(CLK), .MR(MR), .LD(LD), .PRE_T(PRE_T), .PRE_U(PRE_U),
    .START(START), .PAUSE(PAUSE), .TICK(TICK),
    .Q_T(qt_b), .Q_U(qu_b), .BUSY(busy_b), .DONE(done_b), .ALARM(alarm_b)
  );

  assign obs_a = {qt_a, qu_a, busy_a, done_a, alarm_a};
  assign obs_b = {qt_b, qu_b, busy_b, done_b, alarm_b};

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_ALARM} mode_t;
  mode_t m_mode [2];
  int    m_cnt  [2];
  int    m_pre  [2];
  int    m_ticks[2];
  bit    m_done [2];

  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Expected observation vector {Q_T, Q_U, BUSY, DONE, ALARM}.
  function automatic logic [10:0] ev(input int cnt, input bit busy, input bit done, input bit alarm);
    return {to_bcd(cnt), busy, done, alarm};
  endfunction

  function automatic logic [10:0] model_vec(input int i);
    return ev(m_cnt[i], (m_mode[i] == M_RUN) || (m_mode[i] == M_PAUSED),
              m_done[i], m_mode[i] == M_ALARM);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_cnt[i] = 0; m_pre[i] = 0; m_ticks[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit reload);
    m_done[i] = 1'b0;
    if (LD) begin
      m_cnt[i]   = clamp9(PRE_T) * 10 + clamp9(PRE_U);
      m_pre[i]   = m_cnt[i];
      m_ticks[i] = 0;
      m_mode[i]  = M_IDLE;
    end else begin
      case (m_mode[i])
        M_IDLE:   if (START && m_cnt[i] != 0) m_mode[i] = M_RUN;
        M_RUN: begin
          if (PAUSE) m_mode[i] = M_PAUSED;
          else if (TICK) begin
            m_cnt[i] = m_cnt[i] - 1;
            if (m_cnt[i] == 0) begin
              m_mode[i] = M_ALARM; m_ticks[i] = 0; m_done[i] = 1'b1;
            end
          end
        end
        M_PAUSED: if (START) m_mode[i] = M_RUN;
        M_ALARM: begin
          if (TICK) begin
            m_ticks[i] = m_ticks[i] + 1;
            if (m_ticks[i] == ALARM_N) begin
              m_ticks[i] = 0;
              if (reload && m_pre[i] != 0) begin
                m_cnt[i] = m_pre[i]; m_mode[i] = M_RUN;
              end else begin
                m_mode[i] = M_IDLE;
              end
            end
          end
        end
        default: m_mode[i] = M_IDLE;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit ld, input logic [3:0] pt, input logic [3:0] pu,
                       input bit st, input bit pa, input bit tk);
    LD = ld; PRE_T = pt; PRE_U = pu; START = st; PAUSE = pa; TICK = tk;
  endtask

  // One rising edge; the model consumes the same inputs the DUTs sampled.
  task automatic clk_step();
    @(posedge CLK);
    #1;
    if (!MR) begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    MR = 1'b1;
    drive(0, 4'd0, 4'd0, 0, 0, 0);
    model_reset();
    #1;
    checks++;
    if (obs_a !== 11'd0) begin errors++; $display("FAIL reset_a: got %h expected %h", obs_a, 11'd0); end
    checks++;
    if (obs_b !== 11'd0) begin errors++; $display("FAIL reset_b: got %h expected %h", obs_b, 11'd0); end
    @(negedge CLK);
    MR = 1'b0;
  endtask

  task automatic test_countdown();
    logic [10:0] exp;
    drive(1, 4'd2, 4'd3, 0, 0, 0); clk_step();
    exp = ev(23, 0, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL cd_load: got %h expected %h", obs_a, exp); end
    drive(0, 4'd0, 4'd0, 1, 0, 0); clk_step();
    exp = ev(23, 1, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL cd_start: got %h expected %h", obs_a, exp); end
    for (int k = 1; k <= 23; k++) begin
      drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step();
      exp = ev(23 - k, k < 23, k == 23, k == 23);
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL cd_tick%0d: got %h expected %h", k, obs_a, exp); end
    end
    // Alarm phase; START/PAUSE on the second strobe must not disturb it.
    for (int j = 1; j <= ALARM_N; j++) begin
      drive(0, 4'd0, 4'd0, j == 2, j == 2, 1); clk_step();
      exp = ev(0, 0, 0, j < ALARM_N);
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL cd_alarm%0d: got %h expected %h", j, obs_a, exp); end
    end
    exp = ev(23, 1, 0, 0);
    checks++;
    if (obs_b !== exp) begin errors++; $display("FAIL cd_reload_b: got %h expected %h", obs_b, exp); end
  endtask

  task automatic test_pause();
    logic [10:0] exp;
    drive(1, 4'd1, 4'd0, 0, 0, 0); clk_step();
    drive(0, 4'd0, 4'd0, 1, 0, 0); clk_step();
    exp = ev(10, 1, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL pz_start: got %h expected %h", obs_a, exp); end
    for (int k = 1; k <= 3; k++) begin
      drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step();
      exp = ev(10 - k, 1, 0, 0);
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL pz_tick%0d: got %h expected %h", k, obs_a, exp); end
    end
    drive(0, 4'd0, 4'd0, 0, 1, 1); clk_step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step();
      exp = ev(7, 1, 0, 0);
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL pz_hold%0d: got %h expected %h", k, obs_a, exp); end
    end
    drive(0, 4'd0, 4'd0, 1, 0, 0); clk_step();
    drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step();
    exp = ev(6, 1, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL pz_resume: got %h expected %h", obs_a, exp); end
  endtask

  task automatic test_clamp();
    logic [10:0] exp;
    @(negedge CLK); MR = 1'b1; model_reset(); @(negedge CLK); MR = 1'b0;
    drive(0, 4'd0, 4'd0, 1, 0, 0); clk_step();
    exp = ev(0, 0, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL cl_start_zero: got %h expected %h", obs_a, exp); end
    drive(1, 4'd12, 4'd15, 0, 0, 0); clk_step();
    exp = ev(99, 0, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL cl_load: got %h expected %h", obs_a, exp); end
  endtask

  task automatic test_reload();
    logic [10:0] exp;
    drive(1, 4'd0, 4'd2, 0, 0, 0); clk_step();
    drive(0, 4'd0, 4'd0, 1, 0, 0); clk_step();
    drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step();
    drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step();
    exp = ev(0, 0, 1, 1);
    checks++;
    if (obs_b !== exp) begin errors++; $display("FAIL rl_done1: got %h expected %h", obs_b, exp); end
    for (int j = 0; j < ALARM_N; j++) begin drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step(); end
    exp = ev(2, 1, 0, 0);
    checks++;
    if (obs_b !== exp) begin errors++; $display("FAIL rl_reload: got %h expected %h", obs_b, exp); end
    exp = ev(0, 0, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL rl_idle_a: got %h expected %h", obs_a, exp); end
    drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step();
    drive(0, 4'd0, 4'd0, 0, 0, 1); clk_step();
    exp = ev(0, 0, 1, 1);
    checks++;
    if (obs_b !== exp) begin errors++; $display("FAIL rl_done2: got %h expected %h", obs_b, exp); end
  endtask

  task automatic test_abort();
    logic [10:0] exp;
    drive(1, 4'd4, 4'd5, 0, 0, 0); clk_step();
    drive(0, 4'd0, 4'd0, 1, 0, 0); clk_step();
    exp = ev(45, 1, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL ab_run45: got %h expected %h", obs_a, exp); end
    drive(0, 4'd0, 4'd0, 0, 0, 1);
    @(negedge CLK); #2;
    MR = 1'b1; model_reset();
    #1;
    checks++;
    if (obs_a !== 11'd0) begin errors++; $display("FAIL ab_async: got %h expected %h", obs_a, 11'd0); end
    @(posedge CLK); #1;
    checks++;
    if (obs_a !== 11'd0 || obs_b !== 11'd0) begin
      errors++; $display("FAIL ab_held: got %h/%h expected 0", obs_a, obs_b);
    end
    @(negedge CLK); MR = 1'b0;
    drive(0, 4'd0, 4'd0, 1, 0, 0); clk_step();
    checks++;
    if (obs_a !== 11'd0) begin errors++; $display("FAIL ab_start_ignored: got %h expected %h", obs_a, 11'd0); end
    drive(1, 4'd3, 4'd0, 1, 0, 0); clk_step();
    drive(0, 4'd0, 4'd0, 0, 0, 0); clk_step();
    exp = ev(30, 0, 0, 0);
    checks++;
    if (obs_a !== exp) begin errors++; $display("FAIL ab_ld_wins: got %h expected %h", obs_a, exp); end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    bit ld;
    logic [3:0] pt;
    for (int n = 0; n < 1200; n++) begin
      ld = ($urandom_range(0, 99) < 3);
      pt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      drive(ld, pt, 4'($urandom_range(0, 15)),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 60);
      clk_step();
      exp = model_vec(0);
      checks++;
      if (obs_a !== exp) begin errors++; $display("FAIL rnd_a cyc%0d: got %h expected %h", n, obs_a, exp); end
      exp = model_vec(1);
      checks++;
      if (obs_b !== exp) begin errors++; $display("FAIL rnd_b cyc%0d: got %h expected %h", n, obs_b, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_clamp();
    test_reload();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
